// File: rtl/prog_run_pkg.sv
// Shared types and constants for the program loader / run sequencer.
package prog_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_REQ,
        ST_RUN,
        ST_FINISH
    } run_state_t;

    // Cycles the core is held in reset between start and the req pulse.
    localparam int HOLD_CYCLES = 2;

    localparam int D_DEF = 12;
    localparam int W_DEF = 9;
    localparam int C_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with clear, load-to-one and saturation at MAX.
module sat_counter #(
    parameter int             C   = 16,
    parameter logic [C-1:0]   MAX = {C{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load1,
    input  logic         en,
    output logic [C-1:0] cnt,
    output logic         at_max
);

    logic [C-1:0] cnt_q;
    logic [C-1:0] cnt_d;

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX);

    // Next count: clear beats load, load beats increment; never passes MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = C'(1);
        end else if (en && !at_max) begin
            cnt_d = cnt_q + C'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_run_ctrl.sv
// Loader and run sequencer: streams words into imem, then runs the core
// and measures cycles from req to done (or timeout).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | core held in reset; waiting for a load or a start
// ST_LOAD   | accepting words into imem, core held in reset
// ST_HOLD   | core held in reset for HOLD_CYCLES before release
// ST_REQ    | core released, one-cycle req pulse, counter loaded with 1
// ST_RUN    | counting cycles until core_done or MAX_CYCLES
// ST_FINISH | result valid; core held in reset; start re-runs, valid reloads
module prog_run_ctrl
    import prog_run_pkg::*;
#(
    parameter int           D          = D_DEF,
    parameter int           W          = W_DEF,
    parameter int           C          = C_DEF,
    parameter logic [C-1:0] MAX_CYCLES = {C{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         start,
    output logic         imem_wr_en,
    output logic [D-1:0] imem_addr,
    output logic [W-1:0] imem_wr_data,
    output logic         core_reset,
    output logic         core_req,
    input  logic         core_done,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic         overflow,
    output logic [C-1:0] cycle_count
);

    localparam logic [D-1:0] ADDR_LAST = {D{1'b1}};
    localparam logic [1:0]   HOLD_LAST = 2'(HOLD_CYCLES - 1);

    run_state_t   state_q, state_d;
    logic         loaded_q, loaded_d;
    logic         overflow_q, overflow_d;
    logic         timeout_q, timeout_d;
    logic [D-1:0] imem_addr_q, imem_addr_d;
    logic [C-1:0] cycle_count_q, cycle_count_d;
    logic [1:0]   hold_cnt_q, hold_cnt_d;

    logic         cnt_clr, cnt_load1, cnt_en, cnt_at_max;
    logic [C-1:0] cnt;

    sat_counter #(
        .C   (C),
        .MAX (MAX_CYCLES)
    ) u_cycle_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (cnt_clr),
        .load1  (cnt_load1),
        .en     (cnt_en),
        .cnt    (cnt),
        .at_max (cnt_at_max)
    );

    assign imem_addr   = imem_addr_q;
    assign overflow    = overflow_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done        = (state_q == ST_FINISH);

    // Next-state logic plus the combinational loader and core-control outputs.
    always_comb begin
        state_d       = state_q;
        loaded_d      = loaded_q;
        overflow_d    = overflow_q;
        timeout_d     = timeout_q;
        imem_addr_d   = imem_addr_q;
        cycle_count_d = cycle_count_q;
        hold_cnt_d    = hold_cnt_q;
        in_ready      = 1'b0;
        imem_wr_en    = 1'b0;
        imem_wr_data  = '0;
        core_reset    = 1'b1;
        core_req      = 1'b0;
        cnt_clr       = 1'b0;
        cnt_load1     = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                // start wins over a simultaneous in_valid
                if (start && loaded_q) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end else if (in_valid) begin
                    state_d     = ST_LOAD;
                    imem_addr_d = '0;
                    overflow_d  = 1'b0;
                    loaded_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    imem_wr_en   = 1'b1;
                    imem_wr_data = in_data;
                    if (imem_addr_q != ADDR_LAST) begin
                        imem_addr_d = imem_addr_q + D'(1);
                    end
                    if (in_last) begin
                        loaded_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (imem_addr_q == ADDR_LAST) begin
                        overflow_d = 1'b1;
                        loaded_d   = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                cycle_count_d = '0;
                timeout_d     = 1'b0;
                cnt_clr       = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_REQ;
                end else begin
                    hold_cnt_d = hold_cnt_q + 2'd1;
                end
            end
            ST_REQ: begin
                core_reset = 1'b0;
                core_req   = 1'b1;
                cnt_load1  = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                core_reset = 1'b0;
                if (core_done) begin
                    cycle_count_d = cnt;
                    state_d       = ST_FINISH;
                end else if (cnt_at_max) begin
                    cycle_count_d = cnt;
                    timeout_d     = 1'b1;
                    state_d       = ST_FINISH;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            loaded_q      <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
            imem_addr_q   <= '0;
            cycle_count_q <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            loaded_q      <= loaded_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
            imem_addr_q   <= imem_addr_d;
            cycle_count_q <= cycle_count_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Scoreboard bench for prog_run_ctrl: expected imem writes and run results
// are queued by the stimulus and popped by an independent monitor.
module tb_prog_run_ctrl;

    localparam int D = 12;
    localparam int W = 9;
    localparam int C = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         start;
    logic         imem_wr_en;
    logic [D-1:0] imem_addr;
    logic [W-1:0] imem_wr_data;
    logic         core_reset;
    logic         core_req;
    logic         core_done;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         overflow;
    logic [C-1:0] cycle_count;

    prog_run_ctrl #(
        .D          (D),
        .W          (W),
        .C          (C),
        .MAX_CYCLES (16'd20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .start        (start),
        .imem_wr_en   (imem_wr_en),
        .imem_addr    (imem_addr),
        .imem_wr_data (imem_wr_data),
        .core_reset   (core_reset),
        .core_req     (core_req),
        .core_done    (core_done),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .overflow     (overflow),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [D+W-1:0] wr_q[$];
    logic [C+1:0]   fin_q[$];
    logic [D+W-1:0] wr_exp;
    logic [C+1:0]   fin_exp;
    logic           done_prev = 1'b0;
    int             n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word until the DUT accepts it (bounded).
    task automatic send(input logic [W-1:0] data, input logic last);
        logic acc;
        int   k;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 20) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            k++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_handshake: got no accept after %0d cycles, expected accept", k);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: pop and compare on every imem write and every entry to FINISH.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         imem_addr, imem_wr_data);
            end else begin
                wr_exp = wr_q.pop_front();
                chk("imem_write", 32'({imem_addr, imem_wr_data}), 32'(wr_exp));
            end
        end
        if (done === 1'b1 && !done_prev) begin
            if (fin_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish: got cycle_count %0d, expected no finish",
                         cycle_count);
            end else begin
                fin_exp = fin_q.pop_front();
                chk("finish_result", 32'({cycle_count, timeout, overflow}), 32'(fin_exp));
            end
        end
        done_prev = (done === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        start     = 1'b0;
        core_done = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_core_reset", core_reset, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_flags", {timeout, overflow, core_req, imem_wr_en}, 0);
        reset = 1'b1;
        tick();

        // Load three words, then run with done on RUN cycle 10
        wr_q.push_back({12'd0, 9'h1A0});
        wr_q.push_back({12'd1, 9'h0FF});
        wr_q.push_back({12'd2, 9'h123});
        send(9'h1A0, 1'b0);
        send(9'h0FF, 1'b0);
        send(9'h123, 1'b1);
        chk("after_load_busy", busy, 0);
        fin_q.push_back({16'd10, 1'b0, 1'b0});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold1_core_reset", {core_reset, core_req, busy}, 3'b101);
        tick();
        chk("hold2_core_reset", {core_reset, core_req}, 2'b10);
        tick();
        chk("req_pulse", {core_reset, core_req}, 2'b01);
        tick();
        chk("run1_released", {core_reset, core_req}, 2'b00);
        repeat (9) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("finish_status", {done, busy, core_reset}, 3'b101);
        chk("finish_cycle_count", cycle_count, 10);

        // Re-run without reload; no core_done -> timeout at 20
        fin_q.push_back({16'd20, 1'b1, 1'b0});
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, 23);
        chk("timeout_flag", timeout, 1);
        chk("timeout_cycle_count", cycle_count, 20);

        // start and in_valid together in FINISH: HOLD, no write
        fin_q.push_back({16'd3, 1'b0, 1'b0});
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h055;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_wins_state", {busy, in_ready, core_reset}, 3'b101);
        tick();
        chk("hold_clears_timeout", timeout, 0);
        chk("hold_clears_count", cycle_count, 0);
        tick();
        tick();
        repeat (2) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("short_run_done", done, 1);

        // Overflow: 2^D words, no in_last
        for (int i = 0; i < (1 << D); i++) begin
            wr_q.push_back({12'(i), 9'(i * 7)});
            send(9'(i * 7), 1'b0);
        end
        chk("overflow_flag", overflow, 1);
        chk("overflow_no_wrap", imem_addr, 12'hFFF);
        chk("overflow_idle", {busy, done, in_ready}, 3'b000);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_after_overflow", {busy, core_reset}, 2'b01);

        // Reload, then drop reset mid-run
        wr_q.push_back({12'd0, 9'h011});
        wr_q.push_back({12'd1, 9'h022});
        wr_q.push_back({12'd2, 9'h033});
        send(9'h011, 1'b0);
        send(9'h022, 1'b0);
        send(9'h033, 1'b1);
        chk("reload_overflow_cleared", overflow, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_run_released", {busy, core_reset}, 2'b10);
        reset = 1'b0;
        #1;
        chk("async_rst_core_reset", {core_reset, core_req, busy, done}, 4'b1000);
        chk("async_rst_regs", {imem_addr, cycle_count, timeout, overflow, in_ready}, 0);
        tick();
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_unloaded_ignored", {busy, done}, 2'b00);

        chk("scoreboard_drained", wr_q.size() + fin_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
Upstream loader and run sequencer for the 9-bit-ISA core (top_level). Streams machine words over a valid/ready interface into instruction memory, holds the core in reset while loading, releases it, and pulses req. Then counts execution cycles until the core's done flag or a cycle-limit timeout. Reports the result and status to the testbench or host.

Parameters:
D, 12, instruction memory address width; matches the core program counter width.
W, 9, machine word width.
C, 16, cycle counter width.
MAX_CYCLES, 16'hFFFF, run-time limit; timeout when the count reaches this value.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  loader word valid
in_ready  out  1  loader ready; high only in LOAD
in_data  in  W  machine word
in_last  in  1  marks the final word of a program
start  in  1  one-cycle request to run the loaded program
imem_wr_en  out  1  instruction memory write strobe
imem_addr  out  D  instruction memory write address
imem_wr_data  out  W  instruction memory write data
core_reset  out  1  active-high reset to the core
core_req  out  1  one-cycle req pulse to the core
core_done  in  1  core done flag
busy  out  1  high in any state other than IDLE or FINISH
done  out  1  high in FINISH
timeout  out  1  sticky; set when the last run hit MAX_CYCLES
overflow  out  1  sticky; set when a load exceeded 2^D words
cycle_count  out  C  cycles from the req pulse to done, latched at finish

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; loaded=0.
  - All outputs 0, except core_reset=1.
  - imem_addr=0; cycle_count=0.
- States: IDLE, LOAD, HOLD, REQ, RUN, FINISH.
- IDLE:
  - core_reset=1.
  - in_valid seen while in_ready=0 → LOAD next cycle; imem_addr cleared; overflow cleared; no word accepted that cycle.
  - start with loaded=1 → HOLD.
  - start with loaded=0 → ignored.
- LOAD:
  - in_ready=1.
  - Accept rule: on in_valid&in_ready, imem_wr_en=1, imem_wr_data=in_data, and the write uses the current imem_addr. The address increments the next cycle.
  - Accept with in_last → loaded=1, then IDLE.
  - Accept at imem_addr=2^D-1 without in_last → overflow=1, loaded=0, then IDLE. The address does not wrap.
  - All write outputs are combinational from the state and the handshake (zero-latency write).
- HOLD:
  - core_reset=1 for exactly 2 cycles, using an internal counter, then REQ.
  - cycle_count cleared; timeout cleared.
- REQ:
  - core_reset=0, core_req=1 for one cycle, then RUN.
  - The counter is loaded with 1.
- RUN:
  - Counter increments by 1 per cycle and saturates at MAX_CYCLES.
  - core_done=1 → latch the count into cycle_count, then FINISH. This takes priority over timeout in the same cycle.
  - Count reaching MAX_CYCLES without done → timeout=1, then FINISH.
- FINISH:
  - done=1; core_reset=1.
  - start → HOLD, re-running the same program.
  - in_valid → LOAD, using the same rule as IDLE.
  - start and in_valid in the same cycle: start wins.
- start during LOAD, HOLD, REQ or RUN is ignored.
- core_done outside RUN is ignored.
- Asynchronous reset mid-run: the core is immediately held in reset; loaded=0.

Decomposition:
- Package prog_run_pkg: state enum (run_state_t); the HOLD_CYCLES=2 constant; defaults for D, W and C.
- Sub-module sat_counter (parameter C, MAX; inputs clr, load1, en; outputs cnt, at_max). Used for the cycle counter.

Test Plan:
- Load 3 words 0x1A0, 0x0FF, 0x123 with in_last on the third, then start:
  - imem writes go to addresses 0, 1, 2.
  - core_reset is high 2 cycles after start, then core_req pulses, then core_reset drops.
- After req, assert core_done on the 10th RUN cycle → cycle_count=10, done=1, busy=0, core_reset=1.
- With MAX_CYCLES=20 and no core_done → timeout=1 after 20 counted cycles, then FINISH; cycle_count=20.
- Stream 2^D words with in_last never asserted → overflow=1, loaded=0; a subsequent start keeps state at IDLE.
- Drop reset in the middle of RUN:
  - All outputs return to reset values immediately; core_reset=1.
  - start before a new load is ignored.
- In FINISH, assert start and in_valid together → HOLD entered, no imem write. A second start after finish re-runs without reload.
